// File: rtl/rf_pkg.sv
// Shared defaults, architectural register indices and the address type for the
// reg_file_sb register file slice.
package rf_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0] rf_addr_t;

  localparam rf_addr_t REG_ZERO = rf_addr_t'(0);
  localparam rf_addr_t REG_RA   = rf_addr_t'(1);
  localparam rf_addr_t REG_SP   = rf_addr_t'(2);

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue reserves a destination, writeback clears it; a
// same-cycle reserve beats the clear. Lookups return the next-state busy bit.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          clr_en_in,
  input  logic [AW-1:0] clr_addr_in,
  input  logic          rsv_en_in,
  input  logic [AW-1:0] rsv_addr_in,
  input  logic [AW-1:0] lk1_addr_in,
  input  logic [AW-1:0] lk2_addr_in,
  output logic          lk1_busy_out,
  output logic          lk2_busy_out
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic                clr_ok_s;
  logic                rsv_ok_s;

  // Next-state busy vector; register 0 can never be marked when hardwired.
  always_comb begin
    clr_ok_s   = clr_en_in && !((ZERO_REG != 0) && (clr_addr_in == {AW{1'b0}}));
    rsv_ok_s   = rsv_en_in && !((ZERO_REG != 0) && (rsv_addr_in == {AW{1'b0}}));
    busy_nxt_s = busy_r;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_nxt_s[i] = (rsv_ok_s && (rsv_addr_in == AW'(i))) ? 1'b1 :
                      (clr_ok_s && (clr_addr_in == AW'(i))) ? 1'b0 : busy_r[i];
    end
    lk1_busy_out = busy_nxt_s[lk1_addr_in];
    lk2_busy_out = busy_nxt_s[lk2_addr_in];
  end

  // Busy state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with registered two-port read, write bypass and a
// busy scoreboard. Define REG_FILE_DBG_PORT_EN to add the dbg_addr_in/dbg_data_out port.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            rd_en_in,
  input  logic [AW-1:0]   rs1_addr_in,
  input  logic [AW-1:0]   rs2_addr_in,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  output logic            rs1_busy_out,
  output logic            rs2_busy_out,
  output logic            rd_valid_out,
  input  logic            wr_en_in,
  input  logic [AW-1:0]   wr_addr_in,
  input  logic [XLEN-1:0] wr_data_in,
  input  logic            rsv_en_in,
  input  logic [AW-1:0]   rsv_addr_in
`ifdef REG_FILE_DBG_PORT_EN
  ,
  input  logic [AW-1:0]   dbg_addr_in,
  output logic [XLEN-1:0] dbg_data_out
`endif
);

  logic [XLEN-1:0] mem_r [NUM_REGS];
  logic            wr_ok_s;
  logic [XLEN-1:0] rs1_nxt_s;
  logic [XLEN-1:0] rs2_nxt_s;
  logic            busy1_nxt_s;
  logic            busy2_nxt_s;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .clr_en_in    (wr_en_in),
    .clr_addr_in  (wr_addr_in),
    .rsv_en_in    (rsv_en_in),
    .rsv_addr_in  (rsv_addr_in),
    .lk1_addr_in  (rs1_addr_in),
    .lk2_addr_in  (rs2_addr_in),
    .lk1_busy_out (busy1_nxt_s),
    .lk2_busy_out (busy2_nxt_s)
  );

  // Read data selection: hardwired zero, then same-edge write bypass, then array.
  always_comb begin
    wr_ok_s   = wr_en_in && !((ZERO_REG != 0) && (wr_addr_in == {AW{1'b0}}));
    rs1_nxt_s = mem_r[rs1_addr_in];
    rs2_nxt_s = mem_r[rs2_addr_in];
    if ((ZERO_REG != 0) && (rs1_addr_in == {AW{1'b0}})) begin
      rs1_nxt_s = {XLEN{1'b0}};
    end else if (wr_en_in && (wr_addr_in == rs1_addr_in)) begin
      rs1_nxt_s = wr_data_in;
    end else begin
      rs1_nxt_s = mem_r[rs1_addr_in];
    end
    if ((ZERO_REG != 0) && (rs2_addr_in == {AW{1'b0}})) begin
      rs2_nxt_s = {XLEN{1'b0}};
    end else if (wr_en_in && (wr_addr_in == rs2_addr_in)) begin
      rs2_nxt_s = wr_data_in;
    end else begin
      rs2_nxt_s = mem_r[rs2_addr_in];
    end
  end

  // Register array.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_ok_s) begin
      mem_r[wr_addr_in] <= wr_data_in;
    end
  end

  // Read port registers; data and busy hold while no read is requested.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rs1_out      <= {XLEN{1'b0}};
      rs2_out      <= {XLEN{1'b0}};
      rs1_busy_out <= 1'b0;
      rs2_busy_out <= 1'b0;
      rd_valid_out <= 1'b0;
    end else begin
      rd_valid_out <= rd_en_in;
      if (rd_en_in) begin
        rs1_out      <= rs1_nxt_s;
        rs2_out      <= rs2_nxt_s;
        rs1_busy_out <= busy1_nxt_s;
        rs2_busy_out <= busy2_nxt_s;
      end
    end
  end

`ifdef REG_FILE_DBG_PORT_EN
  assign dbg_data_out = ((ZERO_REG != 0) && (dbg_addr_in == {AW{1'b0}})) ?
                        {XLEN{1'b0}} : mem_r[dbg_addr_in];
`endif

endmodule
